// File: rtl/burst_target_mem.sv
// Burst-side target: accepts write bursts into a 2^AW x DW memory and returns read bursts from it,
// with a programmable write ready-throttle and a sticky write-framing error flag.
module burst_target_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic [7:0]    wr_length,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [7:0]    rd_length,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    input  logic [7:0]    cfg_max_burst,
    input  logic          cfg_stall_en,
    input  logic [3:0]    cfg_stall_period,
    output logic          busy,
    output logic          frame_err
);

    // state  | meaning
    // IDLE   | waiting for a first write beat or a read request
    // WRITE  | accepting write beats until len_q beats are stored
    // READ   | returning one beat per cycle while rd_ready is high
    // RD_GAP | one idle cycle between read bursts
    // DONE   | one cycle of completion before IDLE
    typedef enum logic [2:0] {IDLE, WRITE, READ, RD_GAP, DONE} state_t;

    state_t state, state_nx;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] addr, addr_nx;
    logic [7:0]    len_q, len_nx;
    logic [7:0]    beat_cnt, beat_nx, beat_inc;
    logic [8:0]    burst_cnt, burst_nx, burst_inc;
    logic [3:0]    stall_cnt, stall_nx;
    logic [8:0]    max_eff;
    logic          wr_acc, throttle_en, stall_now;
    logic          err_nx, mem_we, rd_ld, rd_valid_nx, rd_last_nx, ready_nx, busy_nx;

    assign max_eff     = (cfg_max_burst == 8'd0) ? 9'd256 : {1'b0, cfg_max_burst};
    assign wr_acc      = wr_valid & wr_ready;
    assign throttle_en = cfg_stall_en && (cfg_stall_period != 4'd0);
    assign beat_inc    = beat_cnt + 8'd1;
    assign burst_inc   = burst_cnt + 9'd1;

    always_comb begin
        state_nx    = state;
        addr_nx     = addr;
        len_nx      = len_q;
        beat_nx     = beat_cnt;
        burst_nx    = burst_cnt;
        stall_nx    = stall_cnt;
        err_nx      = frame_err;
        mem_we      = 1'b0;
        rd_ld       = 1'b0;
        rd_valid_nx = 1'b0;
        rd_last_nx  = 1'b0;
        stall_now   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_acc) begin
                    if (wr_length == 8'd0) begin
                        err_nx = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        len_nx   = wr_length;
                        addr_nx  = addr + 1'b1;
                        beat_nx  = 8'd1;
                        burst_nx = wr_last ? 9'd0 : 9'd1;
                        if (wr_length == 8'd1 && !wr_last) err_nx = 1'b1;
                        // stall_cnt holds beats remaining until the next throttle cycle
                        stall_now = throttle_en && (cfg_stall_period == 4'd1);
                        stall_nx  = stall_now ? cfg_stall_period : cfg_stall_period - 4'd1;
                        state_nx  = (wr_length == 8'd1) ? DONE : WRITE;
                    end
                end else if (rd_req) begin
                    len_nx   = rd_length;
                    addr_nx  = '0;
                    beat_nx  = 8'd0;
                    burst_nx = 9'd0;
                    state_nx = (rd_length == 8'd0) ? DONE : READ;
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    mem_we   = 1'b1;
                    addr_nx  = addr + 1'b1;
                    beat_nx  = beat_inc;
                    burst_nx = wr_last ? 9'd0 : burst_inc;
                    if (burst_inc > max_eff) err_nx = 1'b1;
                    if (beat_inc == len_q) begin
                        state_nx = DONE;
                        if (!wr_last) err_nx = 1'b1;
                    end
                    stall_now = throttle_en && (stall_cnt == 4'd1);
                    stall_nx  = stall_now ? cfg_stall_period : stall_cnt - 4'd1;
                end
            end
            READ: begin
                if (rd_ready) begin
                    rd_ld       = 1'b1;
                    rd_valid_nx = 1'b1;
                    addr_nx     = addr + 1'b1;
                    beat_nx     = beat_inc;
                    burst_nx    = burst_inc;
                    rd_last_nx  = (burst_inc == max_eff) || (beat_inc == len_q);
                    if (beat_inc == len_q)       state_nx = DONE;
                    else if (burst_inc == max_eff) state_nx = RD_GAP;
                end
            end
            RD_GAP: begin
                burst_nx = 9'd0;
                state_nx = READ;
            end
            DONE: begin
                state_nx = IDLE;
                addr_nx  = '0;
                len_nx   = 8'd0;
                beat_nx  = 8'd0;
                burst_nx = 9'd0;
                stall_nx = 4'd0;
            end
            default: state_nx = IDLE;
        endcase
        ready_nx = (state_nx == IDLE) || ((state_nx == WRITE) && !stall_now);
        busy_nx  = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            len_q     <= 8'd0;
            beat_cnt  <= 8'd0;
            burst_cnt <= 9'd0;
            stall_cnt <= 4'd0;
            wr_ready  <= 1'b1;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            len_q     <= len_nx;
            beat_cnt  <= beat_nx;
            burst_cnt <= burst_nx;
            stall_cnt <= stall_nx;
            wr_ready  <= ready_nx;
            rd_valid  <= rd_valid_nx;
            rd_last   <= rd_last_nx;
            busy      <= busy_nx;
            frame_err <= err_nx;
            if (rd_ld) rd_data <= mem[addr];
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wr_data;
    end

endmodule

// File: tb/tb_burst_target_mem.sv
// Testbench for burst_target_mem: table-driven write/read vectors, directed corner sequences
// and randomized transactions against a byte-array reference model.
module tb_burst_target_mem;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic       wr_last = 1'b0;
    logic [7:0] wr_length = 8'd0;
    logic       wr_ready;
    logic       rd_req = 1'b0;
    logic [7:0] rd_length = 8'd0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_last;
    logic [7:0] cfg_max_burst = 8'd0;
    logic       cfg_stall_en = 1'b0;
    logic [3:0] cfg_stall_period = 4'd0;
    logic       busy;
    logic       frame_err;

    burst_target_mem #(.DW(8), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_length(wr_length),
        .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_length(rd_length), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .cfg_max_burst(cfg_max_burst), .cfg_stall_en(cfg_stall_en),
        .cfg_stall_period(cfg_stall_period),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] wd [256];
    bit         wl [256];
    bit         exp_err = 1'b0;

    typedef struct {
        int len;
        int maxb;
        bit sen;
        int per;
        int lmode;      // 0: last at every burst boundary and final, 1: never, 2: final only
        bit exp_err;
        int exp_stalls;
    } wvec_t;

    wvec_t vecs [9];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; wr_last = 1'b0; rd_req = 1'b0; rd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_last(input int len, input int maxb, input int lmode);
        int maxe;
        maxe = (maxb == 0) ? 256 : maxb;
        for (int i = 0; i < len; i++) begin
            case (lmode)
                0:       wl[i] = ((i + 1) % maxe == 0) || (i == len - 1);
                1:       wl[i] = 1'b0;
                default: wl[i] = (i == len - 1);
            endcase
        end
    endtask

    // Drives len beats from wd/wl, records throttle cycles, checks them and the error flag.
    task automatic write_txn(input int len, input int maxb, input bit sen, input int per,
                             input bit with_rd, output int nstalls);
        int acc, cyc, run, maxe, seen_rv;
        int stl[$];
        int exp_stl[$];
        bit e;
        acc = 0; cyc = 0; seen_rv = 0;
        maxe = (maxb == 0) ? 256 : maxb;
        cfg_max_burst = 8'(maxb); cfg_stall_en = sen; cfg_stall_period = 4'(per);
        while (acc < len && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (rd_valid) seen_rv++;
            rd_req = with_rd && (cyc == 1);
            rd_length = 8'd5;
            if (acc > 0 && !wr_ready) stl.push_back(acc);
            wr_valid = 1'b1; wr_data = wd[acc]; wr_last = wl[acc]; wr_length = 8'(len);
            if (wr_ready) acc++;
        end
        if (acc < len) chk("wr_timeout", acc, len);
        @(negedge clk);
        rd_req = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
        if (rd_valid) seen_rv++;
        chk("wr_busy_done", busy, 1);
        chk("wr_ready_done", wr_ready, 0);
        @(negedge clk);
        if (rd_valid) seen_rv++;
        chk("wr_busy_idle", busy, 0);
        chk("wr_ready_idle", wr_ready, 1);
        if (with_rd) chk("rd_dropped", seen_rv, 0);

        for (int i = 0; i < len; i++) ref_mem[i % 256] = wd[i];
        run = 0; e = 1'b0;
        for (int i = 0; i < len; i++) begin
            run++;
            if (run > maxe) e = 1'b1;
            if (wl[i]) run = 0;
        end
        if (!wl[len - 1]) e = 1'b1;
        if (e) exp_err = 1'b1;
        chk("frame_err", frame_err, exp_err);

        if (sen && per != 0)
            for (int k = per; k < len; k += per) exp_stl.push_back(k);
        chk("stall_count", stl.size(), exp_stl.size());
        for (int i = 0; i < stl.size() && i < exp_stl.size(); i++)
            chk("stall_after_beat", stl[i], exp_stl[i]);
        nstalls = stl.size();
    endtask

    // Requests len beats and checks data, last flags, burst gaps, latency and completion.
    task automatic read_txn(input int len, input int maxb, input int drop_at, input int drop_n,
                            input bit rnd);
        int got, cyc, maxe;
        bit pend_gap, exp_last;
        got = 0; cyc = 0; pend_gap = 1'b0;
        maxe = (maxb == 0) ? 256 : maxb;
        cfg_max_burst = 8'(maxb);
        @(negedge clk);
        rd_req = 1'b1; rd_length = 8'(len); rd_ready = 1'b1;
        while (got < len && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            rd_req = 1'b0;
            if (pend_gap) begin
                chk("rd_gap", rd_valid, 0);
                pend_gap = 1'b0;
            end
            if (rd_valid) begin
                if (got == 0 && !rnd) chk("rd_latency", cyc, 2);
                chk("rd_data", rd_data, ref_mem[got]);
                exp_last = (got % maxe == maxe - 1) || (got == len - 1);
                chk("rd_last", rd_last, exp_last);
                if (exp_last && got != len - 1) pend_gap = 1'b1;
                got++;
            end
            rd_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= drop_at && cyc < drop_at + drop_n);
        end
        if (got < len) chk("rd_timeout", got, len);
        if (cyc == 0) begin
            @(negedge clk);
            rd_req = 1'b0;
        end
        @(negedge clk);
        chk("rd_busy_idle", busy, 0);
        chk("rd_valid_idle", rd_valid, 0);
        rd_ready = 1'b0;
    endtask

    initial begin
        int ns, rl;
        vecs[0] = '{4, 4, 1'b0, 0, 0, 1'b0, 0};
        vecs[1] = '{7, 0, 1'b1, 3, 0, 1'b0, 2};
        vecs[2] = '{1, 1, 1'b0, 0, 0, 1'b0, 0};
        vecs[3] = '{5, 2, 1'b1, 1, 0, 1'b0, 4};
        vecs[4] = '{3, 4, 1'b1, 0, 2, 1'b0, 0};
        vecs[5] = '{5, 3, 1'b0, 0, 2, 1'b1, 0};
        vecs[6] = '{4, 0, 1'b0, 0, 1, 1'b1, 0};
        vecs[7] = '{6, 0, 1'b0, 5, 0, 1'b0, 0};
        vecs[8] = '{9, 3, 1'b1, 4, 0, 1'b0, 2};

        do_reset();
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].len; i++)
                wd[i] = (v == 0) ? 8'(17 * (i + 1)) : 8'($urandom_range(0, 255));
            fill_last(vecs[v].len, vecs[v].maxb, vecs[v].lmode);
            write_txn(vecs[v].len, vecs[v].maxb, vecs[v].sen, vecs[v].per, 1'b0, ns);
            chk("vec_frame_err", frame_err, vecs[v].exp_err);
            chk("vec_stalls", ns, vecs[v].exp_stalls);
            read_txn(vecs[v].len, vecs[v].maxb, 0, 0, 1'b0);
            if (v == 0) read_txn(4, 2, 0, 0, 1'b0);
        end

        // framing error: 3 beats without wr_last at max burst 2, then sticky until reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wd[i] = 8'($urandom_range(0, 255));
            wl[i] = (i == 3);
        end
        write_txn(4, 2, 1'b0, 0, 1'b0, ns);
        chk("framing_set", frame_err, 1);
        fill_last(2, 2, 0);
        write_txn(2, 2, 1'b0, 0, 1'b0, ns);
        chk("framing_sticky", frame_err, 1);
        do_reset();
        chk("framing_cleared", frame_err, 0);

        // zero-length write: beat discarded, error set, no transaction
        @(negedge clk);
        wr_valid = 1'b1; wr_length = 8'd0; wr_data = 8'hEE; wr_last = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("len0_busy", busy, 0);
        chk("len0_wr_ready", wr_ready, 1);
        chk("len0_frame_err", frame_err, 1);
        read_txn(1, 0, 0, 0, 1'b0);

        // simultaneous rd_req and first write beat: write wins
        do_reset();
        for (int i = 0; i < 3; i++) wd[i] = 8'($urandom_range(0, 255));
        fill_last(3, 0, 0);
        write_txn(3, 0, 1'b0, 0, 1'b1, ns);
        read_txn(3, 0, 0, 0, 1'b0);

        // rd_ready low for 2 cycles mid-read
        read_txn(6, 0, 3, 2, 1'b0);

        // reset during beat 2 of an 8-beat read
        cfg_max_burst = 8'd0;
        @(negedge clk);
        rd_req = 1'b1; rd_length = 8'd8; rd_ready = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrd_beat2_valid", rd_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_rst_valid", rd_valid, 0);
        chk("midrd_rst_last", rd_last, 0);
        chk("midrd_rst_data", rd_data, 0);
        chk("midrd_rst_busy", busy, 0);
        chk("midrd_rst_wr_ready", wr_ready, 1);
        rd_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        read_txn(3, 0, 0, 0, 1'b0);

        // 255-beat write then another write, read back across the whole range
        do_reset();
        for (int i = 0; i < 255; i++) wd[i] = 8'($urandom_range(0, 255));
        fill_last(255, 0, 0);
        write_txn(255, 0, 1'b0, 0, 1'b0, ns);
        for (int i = 0; i < 3; i++) wd[i] = 8'($urandom_range(0, 255));
        fill_last(3, 0, 0);
        write_txn(3, 0, 1'b0, 0, 1'b0, ns);
        read_txn(255, 0, 0, 0, 1'b0);

        // randomized transactions
        for (int it = 0; it < 25; it++) begin
            int len, maxb, per;
            bit sen;
            len  = $urandom_range(1, 24);
            maxb = $urandom_range(0, 6);
            per  = $urandom_range(0, 5);
            sen  = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                wd[i] = 8'($urandom_range(0, 255));
                wl[i] = ($urandom_range(0, 3) == 0) || ((i == len - 1) && ($urandom_range(0, 5) != 0));
            end
            write_txn(len, maxb, sen, per, 1'b0, ns);
            rl = $urandom_range(0, 30);
            read_txn(rl, $urandom_range(0, 6), 0, 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
